// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'd10;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs.
// clear beats push and pop in the same cycle; push and pop together leave count unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // next-state for pointers, count and storage
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // state register; storage is zeroed so the head reads 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches under a credit limit,
// buffers responses with their PCs, and flushes on redirect.
// Optional macro FETCH_BYPASS_EN: a response arriving while the buffer is empty
// is presented to decode in the same cycle instead of one cycle later.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC_P  = RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_din;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full;
    logic              fifo_push, fifo_pop, fifo_clear;

    logic              credit_ok, redirect, rsp, req_accept, keep, bypass_hit;

    // handshake decode, credit check and decode-side outputs
    always_comb begin
        credit_ok  = ((CW+1)'(outstanding_q) + (CW+1)'(fifo_count)) < (CW+1)'(DEPTH);
        redirect   = clk_en && redirect_valid;
        rsp        = clk_en && mem_rsp_valid;
        mem_req_valid = !rst && clk_en && credit_ok;
        mem_req_addr  = req_pc_q;
        req_accept = mem_req_valid && mem_req_ready;
        keep       = rsp && !redirect && (drop_cnt_q == '0);
`ifdef FETCH_BYPASS_EN
        bypass_hit = keep && fifo_empty;
`else
        bypass_hit = 1'b0;
`endif
        inst_valid = !rst && clk_en && (!fifo_empty || bypass_hit);
        inst_data  = bypass_hit ? mem_rsp_data : fifo_head.inst;
        inst_pc    = bypass_hit ? rsp_pc_q     : fifo_head.pc;
        fifo_clear = redirect;
        fifo_pop   = clk_en && inst_ready && !fifo_empty && !redirect;
        fifo_push  = keep && !(bypass_hit && inst_ready);
        fifo_din.pc   = rsp_pc_q;
        fifo_din.inst = mem_rsp_data;
    end

    // next-state for PCs and in-flight bookkeeping; redirect overrides response handling
    always_comb begin
        req_pc_d      = req_pc_q + ADDR_W'(req_accept);
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_accept) - CW'(rsp);
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            req_pc_d   = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_d;
        end else if (rsp) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                rsp_pc_d = rsp_pc_q + ADDR_W'(1);
            end
        end
    end

    // state register; clk_en low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q      <= RESET_PC_P;
            rsp_pc_q      <= RESET_PC_P;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else if (clk_en) begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifndef SYNTHESIS
    // the credit limit should make a kept response always find room
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));
    // memory must not respond while the stage is stalled
    a_no_rsp_stalled: assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && !clk_en));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [INST_W-1:0] mem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // memory request in flight: address, flush epoch at issue, earliest response cycle
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                ep;
        int                rdy;
    } req_t;

    req_t              mq[$];
    logic [ADDR_W-1:0] bq[$];
    int                epoch;
    int                cyc;
    int                last_rdy;
    logic [ADDR_W-1:0] exp_req;
    logic [ADDR_W-1:0] exp_dec;

    int n_chk = 0;
    int n_bad = 0;

    int k_en, k_ird, k_rdy, k_redir, max_lat;
    logic              force_redir;
    logic [ADDR_W-1:0] force_pc;
    int                force_en_off;
    int                accepts;

    function automatic logic [INST_W-1:0] idata(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic redir, credit, kept, byp, exp_iv, accept, consumed;
        logic [ADDR_W-1:0] exp_pc;
        req_t r;
        int rd;
        @(posedge clk);
        #1;
        cyc++;
        clk_en         = ($urandom_range(99) < k_en);
        if (force_en_off > 0) begin
            clk_en = 1'b0;
            force_en_off--;
        end
        inst_ready     = ($urandom_range(99) < k_ird);
        mem_req_ready  = ($urandom_range(99) < k_rdy);
        redirect_valid = ($urandom_range(99) < k_redir);
        redirect_pc    = ADDR_W'($urandom);
        if (force_redir) begin
            clk_en         = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (clk_en && mq.size() > 0 && mq[0].rdy <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = idata(mq[0].addr);
        end
        @(negedge clk);
        redir  = redirect_valid && clk_en;
        credit = (mq.size() + bq.size()) < DEPTH;
        chk("req_valid", 32'(mem_req_valid), 32'(clk_en && credit));
        if (mem_req_valid) chk("req_addr", 32'(mem_req_addr), 32'(exp_req));
        kept = mem_rsp_valid && !redir && (mq[0].ep == epoch);
        byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp  = kept && (bq.size() == 0);
`endif
        exp_iv = clk_en && (bq.size() > 0 || byp);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (inst_valid && exp_iv) begin
            exp_pc = (bq.size() > 0) ? bq[0] : mq[0].addr;
            chk("inst_pc", 32'(inst_pc), 32'(exp_pc));
            chk("inst_data", inst_data, idata(exp_pc));
        end
        accept = clk_en && credit && mem_req_ready;
        if (accept) begin
            rd = cyc + $urandom_range(max_lat - 1) + 1;
            if (rd < last_rdy) rd = last_rdy;
            last_rdy = rd;
            mq.push_back('{addr: exp_req, ep: epoch, rdy: rd});
            exp_req = exp_req + 1'b1;
            accepts++;
        end
        consumed = exp_iv && inst_ready && !redir;
        if (consumed) begin
            chk("dec_order", 32'(inst_pc), 32'(exp_dec));
            exp_dec = exp_dec + 1'b1;
            if (bq.size() > 0) void'(bq.pop_front());
        end
        if (mem_rsp_valid) begin
            r = mq.pop_front();
            if (kept && !(byp && inst_ready)) bq.push_back(r.addr);
        end
        if (redir) begin
            bq.delete();
            epoch++;
            exp_req = redirect_pc;
            exp_dec = redirect_pc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        epoch = 0; cyc = 0; last_rdy = 0; accepts = 0;
        exp_req = RESET_PC; exp_dec = RESET_PC;
        force_redir = 1'b0; force_pc = '0; force_en_off = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        rst = 1'b0;

        // streaming with 1-cycle memory and decode always ready
        k_en = 100; k_ird = 100; k_rdy = 100; k_redir = 0; max_lat = 1;
        run(20);

        // decode stalled: fetch must stop after the credit is used up
        k_ird = 0;
        run(12);
        chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
        k_ird = 100;
        run(10);

        // redirect in a steady stream (accept and response in the same cycle)
        force_redir = 1'b1; force_pc = 16'h0040;
        run(12);

        // build up outstanding requests with slow memory, then redirect
        max_lat = 3; k_ird = 0;
        run(3);
        force_redir = 1'b1; force_pc = 16'h0040;
        k_ird = 100;
        run(15);

        // PC wrap-around
        max_lat = 1;
        force_redir = 1'b1; force_pc = 16'hFFFE;
        run(10);

        // global stall mid-stream
        force_en_off = 5;
        run(15);

        // randomized traffic
        k_en = 85; k_ird = 60; k_rdy = 70; k_redir = 3; max_lat = 4;
        run(3000);

        chk("some_accepts", 32'(accepts > 100), 32'd1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of decode/execute in core.
- Generates word-addressed PCs and issues in-order read requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight instructions.

Parameters:
- DEPTH, 4, FIFO entries; also the bound on (outstanding requests + buffered entries); power of 2, >=2.
- ADDR_W, 16, PC/address width; word addressed, increment is +1.
- RESET_PC, 10, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global stall; when 0, all state holds.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  word address of request.
- mem_rsp_valid  in  1  response valid; in order; no backpressure.
- mem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes.
- inst_data  out  32  instruction.
- inst_pc  out  ADDR_W  PC of inst_data.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  ADDR_W  new fetch PC.

Behaviour:
- Single clock domain on clk; rst is synchronous and active-high (already decided).
- Reset:
  - req_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, FIFO empty.
  - mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- Credit rule:
  - mem_req_valid = clk_en && (outstanding + fifo_count < DEPTH).
  - mem_req_addr = req_pc.
  - mem_req_valid does not depend on redirect_valid.
- Request accepted (valid && ready): req_pc <= req_pc+1 (mod 2^ADDR_W); outstanding++.
- Response handling (mem_rsp_valid): outstanding--.
  - If drop_cnt>0: discard, drop_cnt--.
  - Else: push {rsp_pc, mem_rsp_data} into the FIFO; rsp_pc++.
- The credit rule guarantees the FIFO is never full on a kept response. Overflow is a sim assertion.
- Decode side:
  - inst_valid = clk_en && fifo non-empty; inst_data/inst_pc = FIFO head.
  - Pop on inst_valid && inst_ready.
  - A push and pop in the same cycle are both honoured.
- Latency: memory response to inst_valid is 1 cycle (registered FIFO write). Redirect to first mem_req_valid with the new PC is 1 cycle.
- Redirect (redirect_valid && clk_en) takes priority over all same-cycle events:
  - FIFO cleared; a same-cycle pop is ignored.
  - req_pc <= redirect_pc; rsp_pc <= redirect_pc.
  - drop_cnt <= outstanding + req_accept - rsp_valid; all in-flight requests, including one accepted this cycle, are dropped.
  - A response arriving in the redirect cycle is discarded, and any existing drop_cnt is subsumed.
  - outstanding still updates normally.
- clk_en=0: no state changes; mem_req_valid=0, inst_valid=0. mem_rsp_valid while clk_en=0 is a protocol violation (sim assertion).
- Counter widths: outstanding and drop_cnt are $clog2(DEPTH)+1 bits and never exceed DEPTH.
- PC wrap-around: 2^ADDR_W-1 -> 0 with no special handling.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty, drop_cnt==0, no redirect, and mem_rsp_valid=1, the response is driven combinationally to inst_data/inst_pc with inst_valid=1.
  - If inst_ready=1, the response is consumed without a FIFO write (0-cycle latency); otherwise it is pushed into the FIFO.
- Undefined: always 1-cycle latency through the FIFO; inst_* driven only from FIFO state.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and INST_W=32 constants.
  - RESET_PC default.
  - typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, clear, count, and head outputs; clear has priority.
- fetch_unit holds the PC counters, outstanding/drop counters and the handshake logic.

Test Plan:
- Reset, mem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests 10,11,12,...; inst_pc sequence 10,11,12 with matching data; inst_valid first asserts 1 cycle after first response.
- inst_ready=0 with memory always ready -> exactly DEPTH (4) requests issued, then mem_req_valid=0; releasing inst_ready resumes fetch with no lost or duplicated PCs.
- 3 requests outstanding, redirect_pc=0x40 -> 3 responses discarded, next inst_pc=0x40, FIFO contents before the redirect never reach decode.
- Redirect in the same cycle as a request accept and a response -> drop_cnt=outstanding+1-1; first delivered inst_pc is the redirect target.
- redirect_pc=0xFFFE -> inst_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- clk_en=0 for 5 cycles mid-stream -> no handshakes and state unchanged; sequence continues intact. Under FETCH_BYPASS_EN, an empty FIFO with a response yields inst_valid in the same cycle.
